// File: rtl/uart_cmd_parser.sv
// -----------------------------------------------------------------------------
// uart_cmd_parser
//
// Byte-stream command parser sitting between a UART receiver and the
// per-channel pattern register banks. Each completed frame produces one
// wr_valid_o strobe carrying the command code, channel index and payload.
// The register banks decode wr_cmd_o and wr_ch_o themselves.
//
// Frames (first byte is the command code):
//   PERIOD : cmd, slow, fast
//   FREQ   : cmd, PACK_NUM pattern bytes
//   DATA   : cmd, ch, PACK_NUM pattern bytes
//   REPEAT : cmd, ch, repeat byte
//   CTRL   : cmd, ch, ctrl byte
// Payload byte k lands in wr_data_o[8k+7:8k]; short payloads are zero-extended.
//
// Errors (one-cycle err_o strobe, code on err_code_o):
//   0 unknown command, 1 channel >= CH_NUM, 2 inter-byte timeout,
//   3 checksum mismatch (only when CMD_CHECKSUM_EN is defined).
//
// Build option:
//   CMD_CHECKSUM_EN - every frame carries a trailing byte equal to the XOR
//                     of all preceding frame bytes, verified in state CHECK.
//
// Ports:
//   clk_i          in   system clock
//   rst_n          in   asynchronous reset, active-high
//   data_i         in   received byte, valid with rx_done_tick_i
//   rx_done_tick_i in   one-cycle byte strobe from UART RX
//   wr_valid_o     out  one-cycle frame-complete strobe
//   wr_cmd_o       out  command code of the completed frame
//   wr_ch_o        out  channel index (0 for PERIOD/FREQ)
//   wr_data_o      out  frame payload, first payload byte in bits [7:0]
//   err_o          out  one-cycle error strobe
//   err_code_o     out  error code of the most recent error
//   busy_o         out  high while a frame is in progress
// -----------------------------------------------------------------------------
module uart_cmd_parser #(
  parameter int         DATA_BIT    = 32,
  parameter int         CH_NUM      = 8,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] CMD_PERIOD  = 8'h01,
  parameter logic [7:0] CMD_FREQ    = 8'h02,
  parameter logic [7:0] CMD_DATA    = 8'h03,
  parameter logic [7:0] CMD_REPEAT  = 8'h04,
  parameter logic [7:0] CMD_CTRL    = 8'h05
) (
  input  logic                      clk_i,
  input  logic                      rst_n,
  input  logic [7:0]                data_i,
  input  logic                      rx_done_tick_i,
  output logic                      wr_valid_o,
  output logic [7:0]                wr_cmd_o,
  output logic [$clog2(CH_NUM)-1:0] wr_ch_o,
  output logic [DATA_BIT-1:0]       wr_data_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o,
  output logic                      busy_o
);

  localparam int PACK_NUM = DATA_BIT / 8;
  localparam int CH_W     = $clog2(CH_NUM);
  localparam int CNT_W    = $clog2(PACK_NUM + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYC);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_CMD     = 2'd0;
  localparam logic [1:0] ERR_CH      = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
`ifdef CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM    = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHAN,
    S_PAYLOAD,
    S_DONE
`ifdef CMD_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t              state_q, state_n;
  logic [7:0]          cmd_q, cmd_n;
  logic [CH_W-1:0]     ch_q, ch_n;
  logic [DATA_BIT-1:0] pay_q, pay_n;
  logic [CNT_W-1:0]    cnt_q, cnt_n;
  logic [TO_W-1:0]     to_q, to_n;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]          csum_q, csum_n;
`endif

  logic                wr_valid_n;
  logic [7:0]          wr_cmd_n;
  logic [CH_W-1:0]     wr_ch_n;
  logic [DATA_BIT-1:0] wr_data_n;
  logic                err_n;
  logic [1:0]          err_code_n;

  // Commands whose frame carries a channel byte after the command code.
  function automatic logic has_chan(input logic [7:0] cmd);
    return (cmd == CMD_DATA) || (cmd == CMD_REPEAT) || (cmd == CMD_CTRL);
  endfunction

  // Commands that go straight from the command byte to the payload.
  function automatic logic no_chan(input logic [7:0] cmd);
    return (cmd == CMD_PERIOD) || (cmd == CMD_FREQ);
  endfunction

  // Number of payload bytes following the command (and channel) byte.
  function automatic logic [CNT_W-1:0] payload_len(input logic [7:0] cmd);
    logic [CNT_W-1:0] len;
    if (cmd == CMD_PERIOD)
      len = CNT_W'(2);
    else if ((cmd == CMD_REPEAT) || (cmd == CMD_CTRL))
      len = CNT_W'(1);
    else
      len = CNT_W'(PACK_NUM);
    return len;
  endfunction

  assign busy_o = (state_q != S_IDLE);

  always_comb begin
    state_n    = state_q;
    cmd_n      = cmd_q;
    ch_n       = ch_q;
    pay_n      = pay_q;
    cnt_n      = cnt_q;
    to_n       = to_q;
    wr_valid_n = 1'b0;
    wr_cmd_n   = wr_cmd_o;
    wr_ch_n    = wr_ch_o;
    wr_data_n  = wr_data_o;
    err_n      = 1'b0;
    err_code_n = err_code_o;
`ifdef CMD_CHECKSUM_EN
    csum_n     = csum_q;
`endif

    case (state_q)
      // DONE behaves like IDLE for an incoming strobe so a command byte
      // arriving right behind the previous frame is not lost.
      S_IDLE, S_DONE: begin
        state_n = S_IDLE;
        to_n    = '0;
        if (rx_done_tick_i) begin
          cmd_n = data_i;
          ch_n  = '0;
          pay_n = '0;
          cnt_n = '0;
`ifdef CMD_CHECKSUM_EN
          csum_n = data_i;
`endif
          if (has_chan(data_i)) begin
            state_n = S_CHAN;
          end else if (no_chan(data_i)) begin
            state_n = S_PAYLOAD;
          end else begin
            err_n      = 1'b1;
            err_code_n = ERR_CMD;
          end
        end
      end

      // In-frame states: CHAN, PAYLOAD and (optionally) CHECK.
      default: begin
        if (rx_done_tick_i) begin
          to_n = '0;
`ifdef CMD_CHECKSUM_EN
          csum_n = csum_q ^ data_i;
`endif
          case (state_q)
            S_CHAN: begin
              if ({24'd0, data_i} < 32'(CH_NUM)) begin
                ch_n    = data_i[CH_W-1:0];
                state_n = S_PAYLOAD;
              end else begin
                err_n      = 1'b1;
                err_code_n = ERR_CH;
                state_n    = S_IDLE;
              end
            end

            S_PAYLOAD: begin
              for (int k = 0; k < PACK_NUM; k++) begin
                if (cnt_q == CNT_W'(k))
                  pay_n[8*k +: 8] = data_i;
              end
              if ((cnt_q + CNT_W'(1)) == payload_len(cmd_q)) begin
`ifdef CMD_CHECKSUM_EN
                state_n = S_CHECK;
`else
                state_n    = S_DONE;
                wr_valid_n = 1'b1;
                wr_cmd_n   = cmd_q;
                wr_ch_n    = ch_q;
                wr_data_n  = pay_n;
`endif
              end else begin
                cnt_n = cnt_q + CNT_W'(1);
              end
            end

`ifdef CMD_CHECKSUM_EN
            S_CHECK: begin
              if (data_i == csum_q) begin
                state_n    = S_DONE;
                wr_valid_n = 1'b1;
                wr_cmd_n   = cmd_q;
                wr_ch_n    = ch_q;
                wr_data_n  = pay_q;
              end else begin
                err_n      = 1'b1;
                err_code_n = ERR_CSUM;
                state_n    = S_IDLE;
              end
            end
`endif

            default: state_n = S_IDLE;
          endcase
        end else if (to_q == TO_LAST) begin
          // This idle cycle brings the gap to TIMEOUT_CYC: drop the frame.
          err_n      = 1'b1;
          err_code_n = ERR_TIMEOUT;
          state_n    = S_IDLE;
          to_n       = '0;
        end else begin
          to_n = to_q + TO_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      ch_q       <= '0;
      pay_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= '0;
`endif
      wr_valid_o <= 1'b0;
      wr_cmd_o   <= '0;
      wr_ch_o    <= '0;
      wr_data_o  <= '0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      state_q    <= state_n;
      cmd_q      <= cmd_n;
      ch_q       <= ch_n;
      pay_q      <= pay_n;
      cnt_q      <= cnt_n;
      to_q       <= to_n;
`ifdef CMD_CHECKSUM_EN
      csum_q     <= csum_n;
`endif
      wr_valid_o <= wr_valid_n;
      wr_cmd_o   <= wr_cmd_n;
      wr_ch_o    <= wr_ch_n;
      wr_data_o  <= wr_data_n;
      err_o      <= err_n;
      err_code_o <= err_code_n;
    end
  end

endmodule
